// File: rtl/serial_alu_pkg.sv
// rtl/serial_alu_pkg.sv - shared encodings for the bit-serial add/subtract sequencer
//
// Purpose : FSM state encodings and operation codes shared by the serial
//           add/subtract datapath and its bench.
// Ports   : none (package)
package serial_alu_pkg;

  // 2'd3 is unused and is decoded as IDLE by the sequencer.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/halfadder.sv
// rtl/halfadder.sv - combinational 1-bit half adder
//
// Purpose : sum = a ^ b, carry = a & b.
// Ports   : a, b (in)  - addend bits
//           s    (out) - sum bit
//           c    (out) - carry bit
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_fa_cell.sv
// rtl/serial_fa_cell.sv - combinational 1-bit full adder from two half adders
//
// Purpose : the single adder cell reused every RUN cycle by the sequencer.
// Ports   : a, b (in)  - operand bits
//           ci   (in)  - carry in
//           s    (out) - sum bit
//           co   (out) - carry out
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  halfadder u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
  halfadder u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

  // Both half-adder carries can never be 1 together, so OR is a full carry.
  assign co = c1 | c2;

endmodule

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial add/subtract sequencer with valid/ready handshakes
//
// Purpose : computes op_a +/- op_b one bit per cycle through a single full
//           adder cell; result appears WIDTH edges after the accept edge.
// Ports   : clk, rst_n            - clock, async active-low reset
//           in_valid/in_ready     - operand handshake
//           op_a, op_b, op_sub    - operands and operation (1 = A-B)
//           flush                 - synchronous abort to IDLE
//           out_valid/out_ready   - result handshake
//           result                - sum/difference
//           carry_out             - carry out of MSB (sub: 1 = no borrow)
//           overflow              - signed overflow
module serial_addsub_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             cmsb;
  logic             accept;
  logic             run_step;
  logic             fa_s;
  logic             fa_c;

  serial_fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN:  if (cnt == CNT_LAST) next_state = ST_DONE;
      ST_DONE: if (out_ready)       next_state = ST_IDLE;
      default: next_state = in_valid ? ST_RUN : ST_IDLE;
    endcase
    if (flush) next_state = ST_IDLE;
  end

  // Output / control decode. in_ready is gated by rst_n so it reads 0 while
  // the block is held in reset even though the state register shows IDLE.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    run_step  = 1'b0;
    case (state)
      ST_RUN:  run_step  = !flush;
      ST_DONE: out_valid = 1'b1;
      default: in_ready  = rst_n;
    endcase
    accept = in_ready && in_valid && !flush;
  end

  // Datapath: operand/result shift registers, bit counter, carry chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      cmsb      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_sr  <= op_a;
      b_sr  <= (op_sub == OP_SUB) ? ~op_b : op_b;
      carry <= (op_sub == OP_SUB);
      cnt   <= '0;
    end else if (run_step) begin
      res_sr <= {fa_s, res_sr[WIDTH-1:1]};
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      carry  <= fa_c;
      if (cnt == CNT_MSB) cmsb <= fa_c;
      if (cnt == CNT_LAST) begin
        carry_out <= fa_c;
        overflow  <= cmsb ^ fa_c;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign result = res_sr;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - self-checking bench for serial_addsub_ctrl
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } vec_t;

  vec_t vecs[10];

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic check8(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Present one operation and let the accept edge happen.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    @(negedge clk);
    check1("in_ready_before_accept", in_ready, 1'b1);
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid is seen (expected: W).
  task automatic wait_done(input bit chk_lat);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = out_valid;
    end
    check1("out_valid_timeout", seen, 1'b1);
    if (chk_lat) check_int("latency_edges", n, W);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check1("consume_out_valid", out_valid, 1'b0);
    check1("consume_in_ready", in_ready, 1'b1);
  endtask

  task automatic check_res(input logic [W-1:0] res, input logic c, input logic v);
    check8("result", result, res);
    check1("carry_out", carry_out, c);
    check1("overflow", overflow, v);
  endtask

  initial begin
    bit seen;

    vecs[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'h3C, 8'h5A, 1'b1, 8'hE2, 1'b0, 1'b0};
    vecs[8] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[9] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    #1;
    check1("post_rst_in_ready", in_ready, 1'b1);
    check1("post_rst_out_valid", out_valid, 1'b0);
    check_res(8'h00, 1'b0, 1'b0);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub);
      wait_done(1'b1);
      check_res(vecs[i].res, vecs[i].c, vecs[i].v);
      consume();
    end

    // Backpressure: outputs hold while out_ready is low, then back-to-back op
    issue(8'h7F, 8'h01, 1'b0);
    wait_done(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1("bp_out_valid", out_valid, 1'b1);
      check1("bp_in_ready", in_ready, 1'b0);
      check_res(8'h80, 1'b0, 1'b1);
    end
    consume();
    issue(8'h01, 8'h02, 1'b0);
    wait_done(1'b1);
    check_res(8'h03, 1'b0, 1'b0);
    consume();

    // Flush during RUN: back to IDLE, no result pulse
    issue(8'h11, 8'h22, 1'b0);
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check1("flush_out_valid", out_valid, 1'b0);
    check1("flush_in_ready", in_ready, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check1("flush_no_valid_pulse", seen, 1'b0);
    issue(8'h10, 8'h20, 1'b0);
    wait_done(1'b1);
    check_res(8'h30, 1'b0, 1'b0);
    consume();

    // Asynchronous reset mid-RUN
    issue(8'h99, 8'h0F, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check1("async_rst_out_valid", out_valid, 1'b0);
    check1("async_rst_in_ready", in_ready, 1'b0);
    check8("async_rst_result", result, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check1("after_rst_in_ready", in_ready, 1'b1);
    issue(8'h55, 8'h0F, 1'b1);
    wait_done(1'b1);
    check_res(8'h46, 1'b1, 1'b0);
    consume();

    // in_valid held with changing operands during RUN/DONE is ignored
    @(negedge clk);
    op_a     = 8'h3C;
    op_b     = 8'h5A;
    op_sub   = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    op_a   = 8'hFF;
    op_b   = 8'hFF;
    op_sub = 1'b0;
    wait_done(1'b1);
    check1("busy_in_ready", in_ready, 1'b0);
    check_res(8'hE2, 1'b0, 1'b0);
    @(negedge clk);
    check1("done_hold_valid", out_valid, 1'b1);
    check_res(8'hE2, 1'b0, 1'b0);
    in_valid = 1'b0;
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
